// File: rtl/btn_press_conditioner.sv
// btn_press_conditioner: synchronizes, debounces and classifies one push-button into press/release/short/long/repeat pulses.
// Define BTN_AUTOREPEAT_EN to issue repeat_pulse every REPEAT_CYCLES while a long press is held.
module btn_press_conditioner #(
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_btn_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_short_pulse,
    output logic o_long_pulse,
    output logic o_repeat_pulse,
    output logic o_step_pulse
);
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [DW-1:0] DEB_END  = DW'(DEB_CYCLES);
    localparam logic [HW-1:0] LONG_END = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} state_t;

    logic          r_sync1, r_sync2;
    logic          r_level;
    logic [DW-1:0] r_deb_cnt;
    logic [HW-1:0] r_hold_cnt;
    state_t        r_state;
    logic          r_press, r_release, r_short, r_long, r_step;
    logic          w_differs, w_flip, w_rise, w_fall;

    assign w_differs = r_sync2 != r_level;
    assign w_flip    = w_differs && (r_deb_cnt == DEB_END);
    assign w_rise    = w_flip && !r_level;
    assign w_fall    = w_flip && r_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_deb_cnt <= (!w_differs || w_flip) ? '0 : r_deb_cnt + 1'b1;
            if (w_flip)
                r_level <= ~r_level;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [HW-1:0] REP_END = HW'(REPEAT_CYCLES - 1);
    logic [HW-1:0] r_rep_cnt;
    logic          r_repeat;
    assign o_repeat_pulse = r_repeat;
`else
    assign o_repeat_pulse = 1'b0;
`endif

    // Debounce events feed the FSM in the same cycle, so pulses align with the btn_level edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_step     <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_rep_cnt  <= '0;
            r_repeat   <= 1'b0;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_step    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_repeat  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_press    <= 1'b1;
                        r_step     <= 1'b1;
                        r_hold_cnt <= '0;
                        r_state    <= S_HELD;
                    end
                end
                S_HELD: begin
                    if (r_hold_cnt != CNT_MAX)
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (w_fall) begin
                        r_release <= 1'b1;
                        r_short   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (r_hold_cnt == LONG_END) begin
                        r_long  <= 1'b1;
                        r_step  <= 1'b1;
                        r_state <= S_LONG;
`ifdef BTN_AUTOREPEAT_EN
                        r_rep_cnt <= '0;
`endif
                    end
                end
                S_LONG: begin
`ifdef BTN_AUTOREPEAT_EN
                    if (r_rep_cnt != CNT_MAX)
                        r_rep_cnt <= r_rep_cnt + 1'b1;
`endif
                    if (w_fall) begin
                        r_release <= 1'b1;
                        r_state   <= S_IDLE;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (r_rep_cnt == REP_END) begin
                        r_repeat  <= 1'b1;
                        r_step    <= 1'b1;
                        r_rep_cnt <= '0;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_btn_level     = r_level;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;
    assign o_short_pulse   = r_short;
    assign o_long_pulse    = r_long;
    assign o_step_pulse    = r_step;
endmodule

// File: doc/btn_press_conditioner.md
# btn_press_conditioner

Conditions one raw push-button input for the timer/clock front panel: 2-flop synchronizer, debouncer, and press classifier. It emits single-cycle press, release, short-press, long-press and auto-repeat pulses. It sits directly upstream of the mode/increment logic, which consumes `step_pulse` to bump the minute and second BCD counters and `short_pulse` for mode and alert-off buttons. One instance per button.

## Interface
- `DEB_CYCLES`, 1_000_000: cycles the synchronized input must differ from the stable level before the level flips (10 ms @ 100 MHz).
- `LONG_CYCLES`, 50_000_000: cycles after `press_pulse` at which a hold becomes a long press.
- `REPEAT_CYCLES`, 10_000_000: auto-repeat period once long.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `btn` in 1: raw, asynchronous, bouncing button level; 1 = pressed.
- `btn_level` out 1: debounced level.
- `press_pulse` out 1: 1-cycle pulse on debounced 0→1.
- `release_pulse` out 1: 1-cycle pulse on debounced 1→0.
- `short_pulse` out 1: 1-cycle pulse on release before the long threshold.
- `long_pulse` out 1: 1-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat_pulse` out 1: 1-cycle pulse every `REPEAT_CYCLES` while long.
- `step_pulse` out 1: `press_pulse | long_pulse | repeat_pulse` (increment stream).

## Operation
- Synchronizer: two flops, both reset to 0. Only the second-stage output (`sync`) is used.
- Debouncer: counter `deb_cnt` (width `$clog2(DEB_CYCLES+1)`).
  - Clears whenever `sync == btn_level`; otherwise increments.
  - On reaching `DEB_CYCLES`, `btn_level` toggles and `deb_cnt` clears.
  - Any glitch shorter than `DEB_CYCLES` cycles is rejected.
- Classifier FSM with states IDLE, HELD, LONG:
  - IDLE: on debounced rise, assert `press_pulse`, clear `hold_cnt`, go to HELD.
  - HELD: `hold_cnt` increments each cycle.
    - Debounced fall: `release_pulse` + `short_pulse`, go to IDLE.
    - Otherwise, when `hold_cnt == LONG_CYCLES-1`: `long_pulse`, clear `rep_cnt`, go to LONG.
  - LONG: `rep_cnt` increments.
    - Debounced fall: `release_pulse` only, go to IDLE.
    - Otherwise, when `rep_cnt == REPEAT_CYCLES-1`: `repeat_pulse`, `rep_cnt` cleared.
- Priority: a release in the same cycle as a threshold or repeat match wins. No `long_pulse`/`repeat_pulse` is issued that cycle; in HELD, `short_pulse` is issued.
- `hold_cnt` and `rep_cnt` saturate-safe: width `$clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1)`, never wrap within a state.
- All outputs are registered. Pulses never exceed one cycle, and at most one of press/release fires per cycle.

## Timing
- Reset: all outputs 0, FSM in IDLE, all counters 0.
  - Reset is honoured mid-hold; no pulse is generated by reset.
  - If `btn` is still high after reset, a fresh debounce produces a new `press_pulse`.
- Latency, `btn` stable change → `btn_level` and `press_pulse`/`release_pulse`: `DEB_CYCLES + 3` clock edges (2 sync + `DEB_CYCLES` count + 1 register).
- With `press_pulse` in cycle P:
  - `long_pulse` fires in cycle P + `LONG_CYCLES`.
  - `repeat_pulse` fires in P + `LONG_CYCLES` + k·`REPEAT_CYCLES`, k ≥ 1.
- `short_pulse` and `release_pulse` coincide, in the same cycle `btn_level` falls.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - LONG state issues `repeat_pulse` as above.
  - `step_pulse` includes repeats.
- Not defined:
  - `rep_cnt` and its logic are removed.
  - `repeat_pulse` is tied to 0.
  - LONG simply waits for release; `step_pulse` = `press_pulse | long_pulse`.

## Test plan
Bench parameters: `DEB_CYCLES`=4, `LONG_CYCLES`=20, `REPEAT_CYCLES`=5; macro defined unless noted.
- Reset, `btn` held 0 for 50 cycles → all outputs 0 throughout.
- `btn` 1 for 3 cycles, then 0; repeat ×5 → no pulse on any output, `btn_level` stays 0.
- `btn` 1 for 12 cycles, then 0 → exactly one `press_pulse`, 7 cycles after the first sampling edge; one `short_pulse` coincident with `release_pulse`; `step_pulse` count 1; `long_pulse` never fires.
- Debounced hold of 40 cycles (release seen at P+40) → `long_pulse` at P+20; `repeat_pulse` at P+25, P+30, P+35 (P+40 suppressed by release); no `short_pulse`; `step_pulse` count 5. Macro undefined → `repeat_pulse` count 0, `step_pulse` count 2.
- Release landing exactly at P+20 → `short_pulse`=1, `long_pulse`=0.
- `reset` asserted at P+10 while `btn` is held, released after 2 cycles → outputs 0 during reset; a new `press_pulse` arrives `DEB_CYCLES`+3 cycles after reset deassert; no spurious `short_pulse`/`release_pulse`.
